uart_top_ctrl: RTL and testbench

UART_TOP_CTRL -- requirements
Module: uart_top

---
 rtl/uart_top_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_top_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top_ctrl.sv
// uart_top_ctrl: register-mapped UART with a per-frame check field.
// Frames carry an even-parity bit by default. Define UART_CRC_EN to compile in
// the CRC-8 frame mode (poly 0x07), selected through CFG.MODE.
// Register map: 0 CFG, 1 CMD, 2 TXDATA, 3 RXDATA, 4 STATUS.
module uart_top_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        rx_int_o,
  output logic        tx_int_o,
  output logic        err_int_o,
  input  logic        cfg_cs_i,
  input  logic        cfg_we_i,
  input  logic [4:0]  cfg_addr_i,
  input  logic [31:0] cfg_data_i,
  output logic [31:0] cfg_data_o
);

  localparam logic [4:0] A_CFG = 5'd0, A_CMD = 5'd1, A_TXD = 5'd2, A_RXD = 5'd3, A_STAT = 5'd4;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_CHECK, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // host-visible registers
  logic [15:0] div_q;
  logic        rx_en_q, tx_en_q, mode_q;
  logic [7:0]  txdata_q, rxdata_q;
  logic        last_err_q;
  logic [31:0] rd_data;
  logic        unused_bits;

  // receiver
  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_div, rx_cnt, rx_half_m1;
  logic [16:0] rx_half;
  logic [2:0]  rx_bit, rx_last;
  logic [7:0]  rx_data, rx_chk;
  logic        rx_tick, rx_bad;

  // transmitter
  tx_state_t   tx_state;
  logic [15:0] tx_div, tx_cnt;
  logic [16:0] tx_sh;
  logic [4:0]  tx_left;
  logic        tx_start;

`ifdef UART_CRC_EN
  logic        rx_mode;

  // MSB-first CRC-8, poly 0x07, init 0, no reflection, no final xor
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign unused_bits = ^cfg_data_i[15:8];
  assign rx_last     = rx_mode ? 3'd7 : 3'd0;
`else
  // parity-only build: MODE is hard-wired to 0
  assign mode_q      = 1'b0;
  assign unused_bits = ^{cfg_data_i[15:8], cfg_data_i[0]};
  assign rx_last     = 3'd0;
`endif

  assign tx_start = cfg_cs_i && cfg_we_i && (cfg_addr_i == A_CMD) && cfg_data_i[0]
                    && tx_en_q && (tx_state == TX_IDLE);

  // host register writes; CMD is consumed directly by the TX FSM via tx_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      rx_en_q  <= 1'b0;
      tx_en_q  <= 1'b0;
      txdata_q <= '0;
`ifdef UART_CRC_EN
      mode_q   <= 1'b0;
`endif
    end else if (cfg_cs_i && cfg_we_i) begin
      case (cfg_addr_i)
        A_CFG: begin
          div_q   <= cfg_data_i[31:16];
          rx_en_q <= cfg_data_i[2];
          tx_en_q <= cfg_data_i[1];
`ifdef UART_CRC_EN
          mode_q  <= cfg_data_i[0];
`endif
        end
        A_TXD:   txdata_q <= cfg_data_i[7:0];
        default: ;
      endcase
    end
  end

  // read mux; unmapped and write-only addresses read 0
  always_comb begin
    rd_data = '0;
    case (cfg_addr_i)
      A_CFG:   rd_data = {div_q, 13'd0, rx_en_q, tx_en_q, mode_q};
      A_TXD:   rd_data = {24'd0, txdata_q};
      A_RXD:   rd_data = {24'd0, rxdata_q};
      A_STAT:  rd_data = {29'd0, last_err_q, rx_state != RX_IDLE, tx_state != TX_IDLE};
      default: rd_data = '0;
    endcase
  end

  // registered read data, valid the cycle after a read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cfg_data_o <= '0;
    else if (cfg_cs_i && !cfg_we_i) cfg_data_o <= rd_data;
    else                           cfg_data_o <= '0;
  end

  // two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
      rx_s3 <= 1'b0;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // first sample lands mid start bit; DIV=0 degenerates to the next cycle
  assign rx_half    = ({1'b0, div_q} + 17'd1) >> 1;
  assign rx_half_m1 = (rx_half == 17'd0) ? 16'd0 : 16'(rx_half - 17'd1);
  assign rx_tick    = (rx_cnt == 16'd0);

  // frame check on the assembled byte and received check field
  always_comb begin
    rx_bad = (rx_chk[7] != ^rx_data);
`ifdef UART_CRC_EN
    if (rx_mode) rx_bad = (rx_chk != crc8(rx_data));
`endif
  end

  // RX FSM: DIV/MODE are latched at the start edge so CFG writes affect the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_div     <= '0;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_data    <= '0;
      rx_chk     <= '0;
      rxdata_q   <= '0;
      last_err_q <= 1'b0;
      rx_int_o   <= 1'b0;
      err_int_o  <= 1'b0;
`ifdef UART_CRC_EN
      rx_mode    <= 1'b0;
`endif
    end else begin
      rx_int_o  <= 1'b0;
      err_int_o <= 1'b0;
      if (rx_state != RX_IDLE) rx_cnt <= rx_tick ? rx_div : rx_cnt - 16'd1;
      case (rx_state)
        RX_IDLE: if (rx_en_q && rx_s3 && !rx_s2) begin
          rx_state <= RX_START;
          rx_cnt   <= rx_half_m1;
          rx_div   <= div_q;
          rx_bit   <= '0;
`ifdef UART_CRC_EN
          rx_mode  <= mode_q;
`endif
        end
        RX_START: if (rx_tick) rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA: if (rx_tick) begin
          rx_data <= {rx_s2, rx_data[7:1]};
          rx_bit  <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_CHECK;
        end
        RX_CHECK: if (rx_tick) begin
          rx_chk <= {rx_s2, rx_chk[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == rx_last) rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_tick) begin
          rx_state <= RX_IDLE;
          if (!rx_s2 || rx_bad) begin
            err_int_o  <= 1'b1;
            last_err_q <= 1'b1;
          end else begin
            rx_int_o   <= 1'b1;
            rxdata_q   <= rx_data;
            last_err_q <= 1'b0;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // TX FSM: whole frame is composed at start and shifted out LSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_o     <= 1'b1;
      tx_int_o <= 1'b0;
      tx_div   <= '0;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_left  <= '0;
    end else begin
      tx_int_o <= 1'b0;
      case (tx_state)
        TX_IDLE: if (tx_start) begin
          tx_state <= TX_SEND;
          tx_o     <= 1'b0;
          tx_div   <= div_q;
          tx_cnt   <= div_q;
`ifdef UART_CRC_EN
          if (mode_q) begin
            tx_sh   <= {1'b1, crc8(txdata_q), txdata_q};
            tx_left <= 5'd17;
          end else begin
            tx_sh   <= {7'h7f, 1'b1, ^txdata_q, txdata_q};
            tx_left <= 5'd10;
          end
`else
          tx_sh   <= {7'h7f, 1'b1, ^txdata_q, txdata_q};
          tx_left <= 5'd10;
`endif
        end
        TX_SEND: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else if (tx_left == 5'd0) begin
            tx_state <= TX_IDLE;
            tx_o     <= 1'b1;
            tx_int_o <= 1'b1;
          end else begin
            tx_o    <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[16:1]};
            tx_left <= tx_left - 5'd1;
            tx_cnt  <= tx_div;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_top_ctrl.sv
// Randomized scoreboard bench for uart_top_ctrl.
module tb_uart_top_ctrl;

`ifdef UART_CRC_EN
  localparam bit HAS_CRC = 1'b1;
`else
  localparam bit HAS_CRC = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, rx_i = 1'b1;
  logic        cfg_cs_i = 1'b0, cfg_we_i = 1'b0;
  logic [4:0]  cfg_addr_i = '0;
  logic [31:0] cfg_data_i = '0, cfg_data_o;
  logic        tx_o, rx_int_o, tx_int_o, err_int_o;

  uart_top_ctrl dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .tx_o(tx_o),
    .rx_int_o(rx_int_o), .tx_int_o(tx_int_o), .err_int_o(err_int_o),
    .cfg_cs_i(cfg_cs_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .cfg_data_o(cfg_data_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_err; logic [7:0] data; } rx_exp_t;
  typedef struct { logic [31:0] bits; int nbits; int div; } tx_exp_t;

  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];
  rx_exp_t mon_e;

  int n_chk = 0, n_fail = 0;
  int n_rx_pulse = 0, n_err_pulse = 0, tx_int_cnt = 0, tx_done = 0, tx_issued = 0;
  int cur_div = 8;
  bit cur_mode = 1'b0;
  logic [7:0] model_rxdata = '0;
  bit model_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as the remainder of d*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  // serial frame, bit 0 = start bit
  function automatic logic [31:0] mk_frame(input logic [7:0] d, input bit mode,
                                           input bit bad_chk, input bit bad_stop);
    logic [7:0] c;
    if (mode) begin
      c = ref_crc(d) ^ {7'd0, bad_chk};
      return {14'd0, !bad_stop, c, d, 1'b0};
    end
    return {21'd0, !bad_stop, (^d) ^ bad_chk, d, 1'b0};
  endfunction

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    cfg_cs_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    @(negedge clk);
    cfg_cs_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
    cfg_cs_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = a;
    @(negedge clk);
    d = cfg_data_o;
    cfg_cs_i = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cfg_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic set_cfg(input int div, input bit rxen, input bit txen, input bit mode);
    cfg_wr(5'd0, {div[15:0], 13'd0, rxen, txen, mode});
    cur_div  = div;
    cur_mode = mode & HAS_CRC;
  endtask

  // drive one frame on rx_i; expect_it pushes the outcome into the scoreboard
  task automatic rx_frame(input logic [7:0] d, input bit mode, input bit bad_chk,
                          input bit bad_stop, input bit expect_it);
    logic [31:0] f;
    int n, div;
    rx_exp_t e;
    div = cur_div;
    f = mk_frame(d, mode, bad_chk, bad_stop);
    n = mode ? 18 : 11;
    if (expect_it) begin
      e.is_err = bad_chk | bad_stop;
      e.data   = d;
      rx_q.push_back(e);
      if (!e.is_err) model_rxdata = d;
      model_err = e.is_err;
    end
    for (int i = 0; i < n; i++) begin
      rx_i = f[i];
      repeat (div + 1) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic rx_drain(input string name);
    for (int k = 0; k < 4 * (cur_div + 1) && rx_q.size() != 0; k++) @(negedge clk);
    check(name, rx_q.size(), 0);
  endtask

  task automatic tx_send(input logic [7:0] d, input logic [31:0] exp_bits);
    tx_exp_t e;
    e.bits = exp_bits; e.nbits = cur_mode ? 18 : 11; e.div = cur_div;
    tx_q.push_back(e);
    tx_issued++;
    cfg_wr(5'd2, {24'hABCDEF, d});
    cfg_wr(5'd1, 32'd1);
  endtask

  task automatic wait_tx(input int target);
    for (int k = 0; k < 20 * (cur_div + 1) + 50 && tx_done < target; k++) @(negedge clk);
    check("tx_complete", tx_done, target);
  endtask

  // RX scoreboard: pop one expectation per interrupt pulse
  always @(negedge clk) begin
    if (tx_int_o) tx_int_cnt++;
    if (rx_int_o || err_int_o) begin
      if (rx_int_o) n_rx_pulse++;
      if (err_int_o) n_err_pulse++;
      check("rx_err_exclusive", rx_int_o & err_int_o, 0);
      if (rx_q.size() == 0) begin
        check("rx_unexpected_pulse", {30'd0, rx_int_o, err_int_o}, 0);
      end else begin
        mon_e = rx_q.pop_front();
        check("rx_pulse_kind", err_int_o, mon_e.is_err);
      end
    end
  end

  // TX monitor: decode tx_o mid-bit against the queued frame
  initial begin : tx_mon
    tx_exp_t e;
    int per, n, early;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (!rst && tx_o === 1'b0) begin
        if (tx_q.size() == 0) begin
          check("tx_unexpected_frame", tx_o, 1);
          for (int k = 0; k < 2000 && tx_o !== 1'b1; k++) @(negedge clk);
        end else begin
          e = tx_q.pop_front();
          per = e.div + 1; n = e.nbits; early = 0; got = '0;
          for (int t = 1; t <= n * per; t++) begin
            @(negedge clk);
            if (t % per == per / 2) got[t / per] = tx_o;
            if (t < n * per && tx_int_o) early++;
            if (t == n * per) begin
              check("tx_int_at_stop_end", tx_int_o, 1);
              check("tx_idle_after_frame", tx_o, 1);
            end
          end
          check("tx_frame_bits", got, e.bits);
          check("tx_int_early", early, 0);
          tx_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] d;
    int base;
    bit m, bc, bs;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_o", tx_o, 1);
    check("reset_ints", {29'd0, rx_int_o, tx_int_o, err_int_o}, 0);
    check("reset_cfg_data_o", cfg_data_o, 0);
    rst = 1'b0;
    @(negedge clk);

    rd_chk("reset_CFG", 5'd0, 0);
    rd_chk("reset_TXDATA", 5'd2, 0);
    rd_chk("reset_RXDATA", 5'd3, 0);
    rd_chk("reset_STATUS", 5'd4, 0);

    // register map
    cfg_wr(5'd0, 32'hFFFF_FFFF);
    rd_chk("cfg_readback_mask", 5'd0, {16'hFFFF, 13'd0, 2'b11, HAS_CRC});
    cfg_wr(5'd1, 32'h0);
    rd_chk("cmd_reads_zero", 5'd1, 0);
    cfg_wr(5'd2, 32'h1234_56A7);
    rd_chk("txdata_readback", 5'd2, 32'hA7);
    cfg_wr(5'd31, 32'hDEAD_BEEF);
    rd_chk("unmapped_reads_zero", 5'd31, 0);

    // directed parity frames
    set_cfg(8 + $urandom_range(0, 8), 1, 1, 0);
    rx_frame(8'hA5, 0, 0, 0, 1);
    rx_drain("drain_a5_good");
    rd_chk("rxdata_a5", 5'd3, 32'hA5);
    rd_chk("status_good", 5'd4, 0);
    rx_frame(8'hA5, 0, 1, 0, 1);
    rx_drain("drain_a5_badpar");
    rd_chk("status_err", 5'd4, 32'h4);
    rx_frame(8'h3C, 0, 0, 1, 1);
    rx_drain("drain_bad_stop");
    rd_chk("rxdata_kept_after_err", 5'd3, 32'hA5);

    // MODE handling
    set_cfg(cur_div, 1, 1, 1);
    if (HAS_CRC) begin
      rx_frame(8'h55, 1, 0, 0, 1);
      rx_drain("drain_crc_good");
      rd_chk("rxdata_crc", 5'd3, 32'h55);
      rx_frame(8'h55, 1, 1, 0, 1);
      rx_drain("drain_crc_bad");
    end else begin
      rx_frame(8'h5A, 0, 0, 0, 1);
      rx_drain("drain_mode_ignored");
      rd_chk("rxdata_mode_ignored", 5'd3, 32'h5A);
    end

    // disabled receiver and start-bit glitch produce nothing
    set_cfg(cur_div, 0, 1, 0);
    rx_frame(8'h81, 0, 0, 0, 0);
    set_cfg(cur_div, 1, 1, 0);
    rx_i = 1'b0; repeat (2) @(negedge clk); rx_i = 1'b1;
    repeat (3 * (cur_div + 1)) @(negedge clk);
    rd_chk("rx_disabled_glitch_status", 5'd4, {29'd0, model_err, 2'b00});
    rd_chk("rx_disabled_rxdata", 5'd3, {24'd0, model_rxdata});

    // back-to-back random frames with 2 idle bit times
    m = HAS_CRC ? 1'($urandom_range(0, 1)) : 1'b0;
    set_cfg(8 + $urandom_range(0, 8), 1, 1, m);
    base = n_rx_pulse + n_err_pulse;
    for (int i = 0; i < 100; i++) begin
      d  = 8'($urandom);
      bc = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 7) == 0);
      rx_frame(d, cur_mode, bc, bs, 1);
      repeat (2 * (cur_div + 1)) @(negedge clk);
    end
    rx_drain("drain_b2b");
    check("b2b_pulse_sum", n_rx_pulse + n_err_pulse - base, 100);
    rd_chk("b2b_rxdata", 5'd3, {24'd0, model_rxdata});
    rd_chk("b2b_status", 5'd4, {29'd0, model_err, 2'b00});

    // CFG change mid-frame applies to the next frame only
    set_cfg(9, 1, 1, 0);
    fork
      rx_frame(8'hC3, 0, 0, 0, 1);
      begin
        repeat (3 * 10) @(negedge clk);
        cfg_wr(5'd0, {16'd14, 13'd0, 3'b110});
      end
    join
    cur_div = 14;
    rx_drain("drain_midframe_cfg");
    rx_frame(8'h96, 0, 0, 0, 1);
    rx_drain("drain_newdiv");
    rd_chk("rxdata_newdiv", 5'd3, 32'h96);

    // transmit: directed 0x55 frame, busy status, CMD while busy ignored
    set_cfg(8 + $urandom_range(0, 8), 1, 1, 0);
    tx_send(8'h55, 32'h4AA);
    rd_chk("status_tx_busy", 5'd4, {29'd0, model_err, 2'b01});
    cfg_wr(5'd1, 32'd1);
    wait_tx(1);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      tx_send(d, mk_frame(d, 0, 0, 0));
      wait_tx(2 + i);
    end
    if (HAS_CRC) begin
      set_cfg(cur_div, 1, 1, 1);
      d = 8'($urandom);
      tx_send(d, mk_frame(d, 1, 0, 0));
      wait_tx(5);
    end
    set_cfg(cur_div, 1, 0, 0);
    cfg_wr(5'd1, 32'd1);
    repeat (3 * (cur_div + 1)) @(negedge clk);
    rd_chk("tx_disabled_idle", 5'd4, {29'd0, model_err, 2'b00});

    // reset in the middle of a received frame
    set_cfg(cur_div, 1, 1, 0);
    rx_i = 1'b0;
    repeat (cur_div + 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_i = 1'($urandom);
      repeat (cur_div + 1) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrx_reset_tx_o", tx_o, 1);
    check("midrx_reset_ints", {29'd0, rx_int_o, tx_int_o, err_int_o}, 0);
    check("midrx_reset_cfg_data_o", cfg_data_o, 0);
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rxdata = '0; model_err = 1'b0;
    repeat (2 * (cur_div + 1)) @(negedge clk);
    rd_chk("midrx_status", 5'd4, 0);
    rd_chk("midrx_cfg", 5'd0, 0);
    set_cfg(cur_div, 1, 1, 0);
    d = 8'($urandom);
    rx_frame(d, 0, 0, 0, 1);
    rx_drain("drain_after_reset");
    rd_chk("rxdata_after_reset", 5'd3, {24'd0, d});

    repeat (4) @(negedge clk);
    check("rx_queue_empty", rx_q.size(), 0);
    check("tx_queue_empty", tx_q.size(), 0);
    check("tx_int_count", tx_int_cnt, tx_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
